// File: rtl/ndp_sum_ctrl.sv
// ndp_sum_ctrl: reads N words through the iob-cache front-end and feeds each
// word to the 4-number sum accelerator using its start/done handshake. It
// accumulates the partial sums, writes the total to a result address and
// then pulses done_o for one cycle.
module ndp_sum_ctrl #(
    parameter int FE_DATA_W = 32,
    parameter int FE_ADDR_W = 32,
    parameter int CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   go_i,
    input  logic [FE_ADDR_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]       n_words_i,
    input  logic [FE_ADDR_W-1:0]   res_addr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FE_DATA_W-1:0]   result_o,
    output logic                   iob_valid_o,
    output logic [FE_ADDR_W-1:0]   iob_addr_o,
    output logic [FE_DATA_W-1:0]   iob_wdata_o,
    output logic [FE_DATA_W/8-1:0] iob_wstrb_o,
    input  logic                   iob_ready_i,
    input  logic                   iob_rvalid_i,
    input  logic [FE_DATA_W-1:0]   iob_rdata_i,
    output logic                   acc_start_o,
    output logic [FE_DATA_W-1:0]   acc_data_o,
    input  logic [FE_DATA_W-1:0]   acc_data_i,
    input  logic                   acc_done_i
);

    // Width of one accelerator partial sum: four bytes summed need 2 extra bits.
    localparam int PS_W   = FE_DATA_W / 4 + 2;
    localparam int STRB_W = FE_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        ACC_START = 3'd3,
        ACC_WAIT  = 3'd4,
        ACC_REL   = 3'd5,
        WR_REQ    = 3'd6,
        FIN       = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [FE_ADDR_W-1:0] addr_q, addr_d;
    logic [FE_ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FE_DATA_W-1:0] accum_q, accum_d;
    logic [FE_DATA_W-1:0] result_q, result_d;
    logic [FE_DATA_W-1:0] adata_q, adata_d;

    // Partial sum from the accelerator, masked to its meaningful width.
    logic [FE_DATA_W-1:0] psum;
    assign psum = {{(FE_DATA_W - PS_W){1'b0}}, acc_data_i[PS_W-1:0]};

    // The upper accelerator result bits carry no information.
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_data_i[FE_DATA_W-1:PS_W];

    // Remaining word count after the word in flight retires.
    logic [CNT_W-1:0] cnt_dec;
    assign cnt_dec = cnt_q - CNT_W'(1);

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    state_d = (n_words_i != '0) ? RD_REQ : WR_REQ;
                end
            end
            RD_REQ: begin
                if (iob_ready_i) begin
                    state_d = iob_rvalid_i ? ACC_START : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    state_d = ACC_START;
                end
            end
            // A stale done (e.g. left over across a reset) must clear first.
            ACC_START: begin
                if (!acc_done_i) begin
                    state_d = ACC_WAIT;
                end
            end
            ACC_WAIT: begin
                if (acc_done_i) begin
                    state_d = ACC_REL;
                end
            end
            ACC_REL: begin
                if (!acc_done_i) begin
                    state_d = (cnt_dec != '0) ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                if (iob_ready_i) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == FIN);
        iob_valid_o = 1'b0;
        iob_addr_o  = '0;
        iob_wdata_o = '0;
        iob_wstrb_o = '0;
        acc_start_o = 1'b0;
        case (state_q)
            RD_REQ: begin
                iob_valid_o = 1'b1;
                iob_addr_o  = addr_q;
            end
            WR_REQ: begin
                iob_valid_o = 1'b1;
                iob_addr_o  = res_addr_q;
                iob_wdata_o = accum_q;
                iob_wstrb_o = {STRB_W{1'b1}};
            end
            // Start is never raised on top of a done still high.
            ACC_START: acc_start_o = !acc_done_i;
            ACC_WAIT:  acc_start_o = 1'b1;
            default: ;
        endcase
    end

    assign result_o   = result_q;
    assign acc_data_o = adata_q;

    // Datapath next-state: job setup, read capture, accumulation, retire.
    always_comb begin
        addr_d     = addr_q;
        res_addr_d = res_addr_q;
        cnt_d      = cnt_q;
        accum_d    = accum_q;
        result_d   = result_q;
        adata_d    = adata_q;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    addr_d     = base_addr_i;
                    res_addr_d = res_addr_i;
                    cnt_d      = n_words_i;
                    accum_d    = '0;
                    result_d   = '0;
                end
            end
            RD_REQ: begin
                if (iob_ready_i && iob_rvalid_i) begin
                    adata_d = iob_rdata_i;
                end
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    adata_d = iob_rdata_i;
                end
            end
            ACC_WAIT: begin
                if (acc_done_i) begin
                    accum_d = accum_q + psum;
                end
            end
            ACC_REL: begin
                if (!acc_done_i) begin
                    cnt_d  = cnt_dec;
                    addr_d = addr_q + FE_ADDR_W'(4);
                end
            end
            WR_REQ: begin
                if (iob_ready_i) begin
                    result_d = accum_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            addr_q     <= '0;
            res_addr_q <= '0;
            cnt_q      <= '0;
            accum_q    <= '0;
            result_q   <= '0;
            adata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            res_addr_q <= res_addr_d;
            cnt_q      <= cnt_d;
            accum_q    <= accum_d;
            result_q   <= result_d;
            adata_q    <= adata_d;
        end
    end

endmodule

// File: tb/tb_ndp_sum_ctrl.sv
// Directed bench for ndp_sum_ctrl with a front-end memory model (configurable
// ready/rvalid stalls) and a simple sum-accelerator model.
module tb_ndp_sum_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        go;
    logic [31:0] base, res;
    logic [15:0] nw;
    logic        busy, done;
    logic [31:0] result;
    logic        valid;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        start;
    logic [31:0] adata_o, adata_i;
    logic        adone;

    ndp_sum_ctrl #(.FE_DATA_W(32), .FE_ADDR_W(32), .CNT_W(16)) dut (
        .clk_i(clk), .arst_i(arst), .go_i(go), .base_addr_i(base),
        .n_words_i(nw), .res_addr_i(res), .busy_o(busy), .done_o(done),
        .result_o(result), .iob_valid_o(valid), .iob_addr_o(addr),
        .iob_wdata_o(wdata), .iob_wstrb_o(wstrb), .iob_ready_i(ready),
        .iob_rvalid_i(rvalid), .iob_rdata_i(rdata), .acc_start_o(start),
        .acc_data_o(adata_o), .acc_data_i(adata_i), .acc_done_i(adone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [31:0]];
    int ready_delay = 0, rvalid_delay = 0;
    int wait_cnt = 0, rv_cnt = 0;
    logic [31:0] rd_pend = '0;
    int rd_cnt = 0, wr_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;

    assign ready = valid && (wait_cnt >= ready_delay);

    always @(posedge clk) begin
        if (arst || !valid || ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (arst) begin
            rv_cnt <= 0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (rv_cnt != 0) begin
                rv_cnt <= rv_cnt - 1;
                if (rv_cnt == 1) begin
                    rvalid <= 1'b1;
                    rdata  <= rd_pend;
                end
            end
            if (valid && ready) begin
                if (wstrb == 4'h0) begin
                    rd_pend <= mem.exists(addr) ? mem[addr] : 32'h0;
                    rv_cnt  <= rvalid_delay + 1;
                    rd_cnt  <= rd_cnt + 1;
                end else begin
                    wr_cnt  <= wr_cnt + 1;
                    wr_addr <= addr;
                    wr_data <= wdata;
                end
            end
        end
    end

    // ---------------- accelerator model ----------------
    logic ph = 1'b0, dq = 1'b0;
    logic hold_done = 1'b0, force_en = 1'b0;
    logic [31:0] force_ps = '0;

    assign adone   = hold_done | dq;
    assign adata_i = force_en ? force_ps
                   : 32'(adata_o[7:0]) + 32'(adata_o[15:8]) + 32'(adata_o[23:16]) + 32'(adata_o[31:24]);

    always @(posedge clk) begin
        if (!start) begin
            ph <= 1'b0;
            dq <= 1'b0;
        end else if (!dq) begin
            if (ph) dq <= 1'b1;
            else    ph <= 1'b1;
        end
    end

    // ---------------- protocol monitors ----------------
    int starts = 0, dones = 0, viol = 0, stab_err = 0;
    logic start_p = 1'b0, stab_pend = 1'b0;
    logic [31:0] adata_p = '0, h_addr = '0, h_wdata = '0;
    logic [3:0]  h_wstrb = '0;

    always @(negedge clk) begin
        if (done) dones <= dones + 1;
        if (start && !start_p) begin
            starts <= starts + 1;
            if (adone) viol <= viol + 1;
        end
        if (start && start_p && adata_o != adata_p) viol <= viol + 1;
        if (!arst && stab_pend &&
            (!valid || addr != h_addr || wdata != h_wdata || wstrb != h_wstrb))
            stab_err <= stab_err + 1;
        stab_pend <= valid && !ready && !arst;
        h_addr  <= addr;
        h_wdata <= wdata;
        h_wstrb <= wstrb;
        start_p <= start;
        adata_p <= adata_o;
    end

    // ---------------- stimulus helpers ----------------
    // Pulses go for one cycle; returns on the falling edge after it was taken.
    task automatic do_go(input logic [31:0] b, input logic [15:0] n, input logic [31:0] r);
        @(negedge clk);
        base = b; nw = n; res = r; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Waits for done_o; cyc counts cycles with the go cycle as cycle 1.
    task automatic wait_done(input int limit, output int cyc, output bit tmo);
        cyc = 2;
        tmo = 1'b0;
        while (!done) begin
            if (cyc >= limit) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        arst = 1'b1; go = 1'b0; base = '0; nw = '0; res = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %h exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if ({valid, addr, wdata, wstrb} !== 69'h0) begin errors++; $display("FAIL reset_iob got v=%h a=%h d=%h s=%h exp 0", valid, addr, wdata, wstrb); end
        checks++; if ({start, adata_o} !== 33'h0) begin errors++; $display("FAIL reset_acc got s=%h d=%h exp 0", start, adata_o); end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc; bit tmo; int r0, w0, d0, s0;
        mem[32'h100] = 32'h01020304;
        mem[32'h104] = 32'h04030201;
        r0 = rd_cnt; w0 = wr_cnt; d0 = dones; s0 = starts;
        do_go(32'h100, 16'd2, 32'h200);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %h exp 1", busy); end
        wait_done(300, cyc, tmo);
        checks++; if (tmo || cyc != 17) begin errors++; $display("FAIL basic_latency got %0d (timeout %0d) exp 17", cyc, tmo); end
        @(negedge clk);
        checks++; if (result !== 32'h14) begin errors++; $display("FAIL basic_result got %h exp 14", result); end
        checks++; if (wr_addr !== 32'h200 || wr_data !== 32'h14) begin errors++; $display("FAIL basic_write got %h@%h exp 14@200", wr_data, wr_addr); end
        checks++; if (rd_cnt - r0 != 2 || wr_cnt - w0 != 1) begin errors++; $display("FAIL basic_counts got rd=%0d wr=%0d exp 2 1", rd_cnt - r0, wr_cnt - w0); end
        checks++; if (starts - s0 != 2 || dones - d0 != 1) begin errors++; $display("FAIL basic_handshakes got st=%0d dn=%0d exp 2 1", starts - s0, dones - d0); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%h done=%h exp 0 0", busy, done); end
        repeat (4) @(negedge clk);
        checks++; if (result !== 32'h14) begin errors++; $display("FAIL basic_result_hold got %h exp 14", result); end
    endtask

    task automatic test_zero_words;
        int cyc; bit tmo; int r0, d0, s0;
        r0 = rd_cnt; d0 = dones; s0 = starts;
        do_go(32'h100, 16'd0, 32'h300);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL zero_result_clear got %h exp 0", result); end
        wait_done(50, cyc, tmo);
        checks++; if (tmo || cyc != 3) begin errors++; $display("FAIL zero_latency got %0d (timeout %0d) exp 3", cyc, tmo); end
        @(negedge clk);
        checks++; if (wr_addr !== 32'h300 || wr_data !== 32'h0) begin errors++; $display("FAIL zero_write got %h@%h exp 0@300", wr_data, wr_addr); end
        checks++; if (rd_cnt != r0 || starts != s0 || dones - d0 != 1) begin errors++; $display("FAIL zero_counts got rd=%0d st=%0d dn=%0d exp 0 0 1", rd_cnt - r0, starts - s0, dones - d0); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL zero_result got %h exp 0", result); end
    endtask

    task automatic test_stalls;
        int cyc; bit tmo; int e0;
        e0 = stab_err;
        ready_delay = 5; rvalid_delay = 3;
        do_go(32'h100, 16'd2, 32'h240);
        wait_done(400, cyc, tmo);
        checks++; if (tmo || cyc <= 17) begin errors++; $display("FAIL stall_done got %0d (timeout %0d) exp >17 no timeout", cyc, tmo); end
        @(negedge clk);
        checks++; if (result !== 32'h14 || wr_data !== 32'h14 || wr_addr !== 32'h240) begin errors++; $display("FAIL stall_result got %h write %h@%h exp 14 14@240", result, wr_data, wr_addr); end
        checks++; if (stab_err != e0) begin errors++; $display("FAIL stall_stability got %0d unstable cycles exp 0", stab_err - e0); end
        ready_delay = 0; rvalid_delay = 0;
    endtask

    task automatic test_all_ones;
        int cyc; bit tmo;
        for (int i = 0; i < 4; i++) mem[32'h400 + 32'(4 * i)] = 32'hFFFFFFFF;
        do_go(32'h400, 16'd4, 32'h480);
        wait_done(300, cyc, tmo);
        checks++; if (tmo || cyc != 31) begin errors++; $display("FAIL ones_latency got %0d (timeout %0d) exp 31", cyc, tmo); end
        @(negedge clk);
        checks++; if (result !== 32'hFF0 || wr_data !== 32'hFF0) begin errors++; $display("FAIL ones_result got %h write %h exp ff0", result, wr_data); end
    endtask

    task automatic test_wrap;
        int cyc; bit tmo;
        mem[32'h600] = 32'h0;
        force_en = 1'b1; force_ps = 32'h20;
        do_go(32'h600, 16'd1, 32'h700);
        force dut.accum_q = 32'hFFFFFFF0;
        @(negedge clk);
        release dut.accum_q;
        wait_done(100, cyc, tmo);
        @(negedge clk);
        checks++; if (tmo || result !== 32'h10 || wr_data !== 32'h10) begin errors++; $display("FAIL wrap_result got %h write %h (timeout %0d) exp 10", result, wr_data, tmo); end
        force_en = 1'b0;
    endtask

    task automatic test_go_while_busy;
        int cyc; bit tmo; int d0, w0;
        d0 = dones; w0 = wr_cnt;
        do_go(32'h100, 16'd2, 32'h200);
        repeat (5) @(negedge clk);
        base = 32'h900; nw = 16'd0; res = 32'h500; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(300, cyc, tmo);
        repeat (6) @(negedge clk);
        checks++; if (tmo || result !== 32'h14 || wr_addr !== 32'h200) begin errors++; $display("FAIL busy_go_result got %h write@%h (timeout %0d) exp 14 @200", result, wr_addr, tmo); end
        checks++; if (dones - d0 != 1 || wr_cnt - w0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_go_single got dn=%0d wr=%0d busy=%h exp 1 1 0", dones - d0, wr_cnt - w0, busy); end
    endtask

    task automatic test_reset_stale_done;
        int cyc; bit tmo; int n; int s0, w0;
        mem[32'h800] = 32'h01010101;
        w0 = wr_cnt;
        do_go(32'h100, 16'd2, 32'h200);
        n = 0;
        while (!(start && adone) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL stale_reach_accwait got timeout exp accelerator done"); end
        hold_done = 1'b1; arst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, result, valid, wstrb, start, adata_o} !== 71'h0) begin errors++; $display("FAIL stale_reset_outputs got b=%h d=%h r=%h v=%h s=%h st=%h ad=%h exp 0", busy, done, result, valid, wstrb, start, adata_o); end
        arst = 1'b0;
        s0 = starts;
        do_go(32'h800, 16'd1, 32'h880);
        repeat (10) @(negedge clk);
        checks++; if (starts != s0 || busy !== 1'b1 || start !== 1'b0) begin errors++; $display("FAIL stale_start_blocked got st=%0d busy=%h start=%h exp 0 1 0", starts - s0, busy, start); end
        hold_done = 1'b0;
        wait_done(100, cyc, tmo);
        @(negedge clk);
        checks++; if (tmo || result !== 32'h4 || starts - s0 != 1) begin errors++; $display("FAIL stale_resume got %h st=%0d (timeout %0d) exp 4 1", result, starts - s0, tmo); end
        checks++; if (wr_cnt - w0 != 1 || wr_addr !== 32'h880) begin errors++; $display("FAIL stale_writes got %0d @%h exp 1 @880", wr_cnt - w0, wr_addr); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_words;
        test_stalls;
        test_all_ones;
        test_wrap;
        test_go_while_busy;
        test_reset_stale_done;
        checks++; if (viol != 0) begin errors++; $display("FAIL acc_protocol got %0d violations exp 0", viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ndp_sum_ctrl.md
# ndp_sum_ctrl

Sequencer that drives the 4-number sum accelerator from the iob-cache front-end. On a host `go_i` it reads N consecutive 32-bit words from memory, pushes each through the accelerator with the start/done handshake, and accumulates the per-word partial sums into one total. It then writes the total back to a result address and raises a one-cycle completion pulse. It sits between the host/CSR logic, the cache front-end port and one accelerator instance.

## Interface
- `FE_DATA_W`, 32, data width of the cache front-end and accelerator words.
- `FE_ADDR_W`, 32, byte-address width on the front-end.
- `CNT_W`, 16, width of the word-count input.
- `clk_i`  in  1  clock; all logic on rising edge.
- `arst_i`  in  1  reset; synchronous and active-high: sampled only on the rising edge of `clk_i`.
- `go_i`  in  1  start a job; sampled only in IDLE.
- `base_addr_i`  in  FE_ADDR_W  byte address of the first input word; must be word aligned.
- `n_words_i`  in  CNT_W  number of input words; 0 is legal.
- `res_addr_i`  in  FE_ADDR_W  byte address for the result write.
- `busy_o`  out  1  high from the cycle after go is accepted until `done_o`.
- `done_o`  out  1  one-cycle pulse when the result write completes.
- `result_o`  out  FE_DATA_W  final total; held until the next accepted go.
- `iob_valid_o`  out  1  front-end request valid.
- `iob_addr_o`  out  FE_ADDR_W  request address.
- `iob_wdata_o`  out  FE_DATA_W  write data.
- `iob_wstrb_o`  out  FE_DATA_W/8  write strobes; 0 means read.
- `iob_ready_i`  in  1  request accepted this cycle.
- `iob_rvalid_i`  in  1  read data valid.
- `iob_rdata_i`  in  FE_DATA_W  read data.
- `acc_start_o`  out  1  accelerator start.
- `acc_data_o`  out  FE_DATA_W  accelerator input word.
- `acc_data_i`  in  FE_DATA_W  accelerator result.
- `acc_done_i`  in  1  accelerator done.

## Operation
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The internal address, count and accumulator registers are 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, ACC_START, ACC_WAIT, ACC_REL, WR_REQ, FIN.
- IDLE:
  - On `go_i`: latch the three inputs, clear the accumulator and `result_o`, set `busy_o`.
  - Go to RD_REQ if `n_words_i` != 0, otherwise go to WR_REQ.
  - `go_i` in any state other than IDLE is ignored.
- RD_REQ:
  - Drive `iob_valid_o`=1, address = current address, `iob_wstrb_o`=0.
  - Hold the request until `iob_ready_i`.
  - Then drop valid and go to RD_WAIT.
  - If `iob_rvalid_i` arrives in the same cycle as `iob_ready_i`, capture the data and go straight to ACC_START.
- RD_WAIT: on `iob_rvalid_i`, latch `iob_rdata_i` into `acc_data_o`, go to ACC_START.
- ACC_START:
  - Wait until `acc_done_i`=0, which covers an accelerator left in DONE by a mid-operation reset.
  - Then assert `acc_start_o`=1 with `acc_data_o` stable and go to ACC_WAIT.
- ACC_WAIT:
  - Keep `acc_start_o`=1.
  - On `acc_done_i`=1: add the low FE_DATA_W/4+2 bits of `acc_data_i`, zero-extended, to the accumulator.
  - Drop `acc_start_o` and go to ACC_REL.
- ACC_REL:
  - Wait for `acc_done_i`=0.
  - Then decrement the count and add 4 to the address.
  - Go to RD_REQ if the count is still nonzero, otherwise go to WR_REQ.
- WR_REQ:
  - Drive valid, address = `res_addr_i`, `iob_wdata_o` = accumulator, `iob_wstrb_o` all ones.
  - On `iob_ready_i`: drop valid, copy the accumulator to `result_o`, go to FIN.
- FIN: pulse `done_o` for one cycle, clear `busy_o`, go to IDLE.
- Arithmetic and width rules:
  - The accumulator is FE_DATA_W bits unsigned and wraps modulo 2^FE_DATA_W.
  - The address increments modulo 2^FE_ADDR_W.
- Reset asserted in any state:
  - Returns the block to its reset values on that edge.
  - Any pending front-end request is abandoned: valid drops the next cycle.
  - No write completes.

## Timing
- Read with zero-wait memory (ready in the same cycle as valid, rvalid on the next cycle): RD_REQ 1 cycle, RD_WAIT 1 cycle.
- Accelerator round trip: ACC_START 1 cycle, ACC_WAIT 2 cycles, ACC_REL 2 cycles.
- Per-word total: 7 cycles.
- Job latency: `busy_o` rises 1 cycle after go.
  - Total go-to-done is 1 + 7·N + 1 (write) + 1 cycles with zero-wait memory.
  - With N=2 that is 17 cycles.
- `acc_data_o` never changes while `acc_start_o`=1.
- `acc_start_o` is never asserted while `acc_done_i`=1.
- `iob_valid_o` never drops before `iob_ready_i`, except on reset.
- Address and data are stable for the whole time valid is high.

## Test plan
- N=2, base 0x100, words 0x01020304 and 0x04030201, result address 0x200:
  - Partial sums are 10 and 10.
  - Expect a write of 0x00000014 to 0x200, `result_o`=0x14, one `done_o` pulse after 17 cycles.
- N=0, go: no reads, no accelerator start, write of 0 to `res_addr_i`, `done_o` pulse, `result_o`=0.
- Memory stalls: hold `iob_ready_i` low for 5 cycles and delay `iob_rvalid_i` by 3 cycles.
  - Expect valid and address held stable throughout, and the same sum as with zero-wait memory.
- Reset in ACC_WAIT while the accelerator model holds `acc_done_i`=1:
  - Outputs return to 0.
  - A new go waits in ACC_START until `acc_done_i`=0 before raising start.
- Four words of 0xFFFFFFFF: each partial sum is 0x3FC; expect a result of 0xFF0.
- Preloaded accumulator of 0xFFFFFFF0 plus a partial sum of 0x20 (forced) gives 0x10, showing wrap.
- `go_i` pulsed while busy: ignored, job result unchanged, exactly one `done_o`.
